// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - shared register map, FSM states and reset defaults for the UART register block
package apb_uart_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'h0;
    localparam logic [2:0] ADDR_ERROR  = 3'h1;
    localparam logic [2:0] ADDR_BP_LO  = 3'h2;
    localparam logic [2:0] ADDR_BP_HI  = 3'h3;
    localparam logic [2:0] ADDR_DSIZE  = 3'h4;
    localparam logic [2:0] ADDR_RXDATA = 3'h6;

    localparam logic [13:0] BIT_PERIOD_RST = 14'd10;
    localparam logic [3:0]  DATA_SIZE_RST  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_ERROR
    } apb_state_t;

    function automatic logic addr_readable(input logic [2:0] a);
        return (a != 3'h5) && (a != 3'h7);
    endfunction

    function automatic logic addr_writable(input logic [2:0] a);
        return (a == ADDR_BP_LO) || (a == ADDR_BP_HI) || (a == ADDR_DSIZE);
    endfunction

endpackage

// File: rtl/apb_uart_regs.sv
// rtl/apb_uart_regs.sv - APB register slave configuring and reading the UART receiver
module apb_uart_regs
    import apb_uart_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [2:0]  paddr,
    input  logic [7:0]  pwdata,
    output logic [7:0]  prdata,
    output logic        pslverr,
    input  logic [7:0]  rx_data,
    input  logic        data_ready,
    input  logic        overrun_error,
    input  logic        framing_error,
    output logic        data_read,
    output logic [13:0] bit_period,
    output logic [3:0]  data_size
);

    apb_state_t state;
    logic [2:0] addr_q;
    logic [7:0] rd_mux;

    // Address and direction are captured in the setup phase so the access phase ignores bus changes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            addr_q     <= 3'h0;
            bit_period <= BIT_PERIOD_RST;
            data_size  <= DATA_SIZE_RST;
            data_read  <= 1'b0;
        end else begin
            data_read <= (state == ST_READ) && (addr_q == ADDR_RXDATA);
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        addr_q <= paddr;
                        if (pwrite)
                            state <= addr_writable(paddr) ? ST_WRITE : ST_ERROR;
                        else
                            state <= addr_readable(paddr) ? ST_READ : ST_ERROR;
                    end
                end
                ST_WRITE: begin
                    case (addr_q)
                        ADDR_BP_LO: bit_period[7:0]  <= pwdata;
                        ADDR_BP_HI: bit_period[13:8] <= pwdata[5:0];
                        ADDR_DSIZE: data_size        <= pwdata[3:0];
                        default: ;
                    endcase
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            ADDR_STATUS: rd_mux = {7'b0, data_ready};
            ADDR_ERROR:  rd_mux = {6'b0, overrun_error, framing_error};
            ADDR_BP_LO:  rd_mux = bit_period[7:0];
            ADDR_BP_HI:  rd_mux = {2'b0, bit_period[13:8]};
            ADDR_DSIZE:  rd_mux = {4'b0, data_size};
            ADDR_RXDATA: rd_mux = rx_data;
            default:     rd_mux = 8'h00;
        endcase
    end

    assign prdata  = (state == ST_READ) ? rd_mux : 8'h00;
    assign pslverr = (state == ST_ERROR);

endmodule

// File: tb/tb_apb_uart_regs.sv
// tb/tb_apb_uart_regs.sv - vector-table and scoreboard bench for apb_uart_regs
module tb_apb_uart_regs;

    logic        tb_clk;
    logic        n_rst;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pslverr;
    logic [7:0]  rx_data;
    logic        data_ready, overrun_error, framing_error;
    logic        data_read;
    logic [13:0] bit_period;
    logic [3:0]  data_size;

    apb_uart_regs dut (
        .clk(tb_clk), .n_rst(n_rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
        .rx_data(rx_data), .data_ready(data_ready),
        .overrun_error(overrun_error), .framing_error(framing_error),
        .data_read(data_read), .bit_period(bit_period), .data_size(data_size)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rx;
        logic       rdy;
        logic       fe;
        logic       oe;
        logic [7:0] exp_prdata;
        logic       exp_err;
        logic       exp_pulse;
    } vec_t;

    typedef struct {
        logic [7:0] prdata;
        logic       pslverr;
        logic       pulse;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] bp_m;
    logic [3:0]  ds_m;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1 with the bus idle, so consecutive calls run back-to-back.
    task automatic apb(input vec_t v);
        exp_t e;
        e.prdata = v.exp_prdata; e.pslverr = v.exp_err; e.pulse = v.exp_pulse;
        sb.push_back(e);
        rx_data = v.rx; data_ready = v.rdy; framing_error = v.fe; overrun_error = v.oe;
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata;
        @(posedge tb_clk); #1;
        penable = 1'b1;
        #1;
        e = sb.pop_front();
        check("prdata", {8'h0, prdata}, {8'h0, e.prdata});
        check("pslverr", {15'h0, pslverr}, {15'h0, e.pslverr});
        check("data_read_idle_in_access", {15'h0, data_read}, 16'h0);
        @(posedge tb_clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("data_read_pulse", {15'h0, data_read}, {15'h0, e.pulse});
        if (!v.exp_err && v.wr) begin
            case (v.addr)
                3'h2: bp_m[7:0]  = v.wdata;
                3'h3: bp_m[13:8] = v.wdata[5:0];
                3'h4: ds_m       = v.wdata[3:0];
                default: ;
            endcase
        end
        check("bit_period", {2'b0, bit_period}, {2'b0, bp_m});
        check("data_size", {12'h0, data_size}, {12'h0, ds_m});
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                                input logic [7:0] rx, input logic rdy, input logic fe, input logic oe,
                                input logic [7:0] ep, input logic ee, input logic epu);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.rx = rx; v.rdy = rdy; v.fe = fe; v.oe = oe;
        v.exp_prdata = ep; v.exp_err = ee; v.exp_pulse = epu;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        n_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 3'h0; pwdata = 8'h0;
        rx_data = 8'h0; data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
        bp_m = 14'd10; ds_m = 4'd8;

        vecs.push_back(mk(0, 3'h2, 8'h00, 8'h00, 0, 0, 0, 8'h0A, 0, 0));
        vecs.push_back(mk(0, 3'h3, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'h4, 8'h00, 8'h00, 0, 0, 0, 8'h08, 0, 0));
        vecs.push_back(mk(1, 3'h3, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'h2, 8'h34, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'h3, 8'h00, 8'h00, 0, 0, 0, 8'h3F, 0, 0));
        vecs.push_back(mk(0, 3'h2, 8'h00, 8'h00, 0, 0, 0, 8'h34, 0, 0));
        vecs.push_back(mk(0, 3'h6, 8'h00, 8'hA5, 1, 0, 0, 8'hA5, 0, 1));
        vecs.push_back(mk(0, 3'h6, 8'h00, 8'h3C, 0, 0, 0, 8'h3C, 0, 1));
        vecs.push_back(mk(0, 3'h1, 8'h00, 8'h00, 0, 1, 1, 8'h03, 0, 0));
        vecs.push_back(mk(0, 3'h1, 8'h00, 8'h00, 0, 0, 1, 8'h02, 0, 0));
        vecs.push_back(mk(0, 3'h0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'h0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk(1, 3'h0, 8'h55, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 3'h5, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 3'h7, 8'hAA, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 3'h6, 8'h11, 8'h77, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 3'h2, 8'h00, 8'h00, 0, 0, 0, 8'h34, 0, 0));
        vecs.push_back(mk(1, 3'h4, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'h4, 8'h00, 8'h00, 0, 0, 0, 8'h0F, 0, 0));
        vecs.push_back(mk(1, 3'h4, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'h4, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'h2, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'h3, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));

        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_prdata", {8'h0, prdata}, 16'h0);
        check("rst_pslverr", {15'h0, pslverr}, 16'h0);
        check("rst_data_read", {15'h0, data_read}, 16'h0);
        check("rst_bit_period", {2'b0, bit_period}, 16'd10);
        check("rst_data_size", {12'h0, data_size}, 16'd8);
        n_rst = 1'b1;
        @(posedge tb_clk); #1;

        for (int i = 0; i < vecs.size(); i++) apb(vecs[i]);

        // Access-phase changes to paddr/pwrite must not alter the decoded transfer.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'h4; pwdata = 8'h00;
        @(posedge tb_clk); #1;
        penable = 1'b1; pwrite = 1'b1; paddr = 3'h6; pwdata = 8'h09;
        #1;
        check("latched_addr_prdata", {8'h0, prdata}, 16'h0);
        check("latched_addr_pslverr", {15'h0, pslverr}, 16'h0);
        @(posedge tb_clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("latched_addr_no_pulse", {15'h0, data_read}, 16'h0);
        check("latched_addr_no_write", {12'h0, data_size}, {12'h0, ds_m});

        // A lone penable without psel is ignored.
        penable = 1'b1; pwrite = 1'b0; paddr = 3'h5;
        @(posedge tb_clk); #1;
        check("stray_penable_pslverr", {15'h0, pslverr}, 16'h0);
        @(posedge tb_clk); #1;
        check("stray_penable_pslverr2", {15'h0, pslverr}, 16'h0);
        check("stray_penable_prdata", {8'h0, prdata}, 16'h0);
        penable = 1'b0;

        // Reset during the access phase of a write aborts it.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'h4; pwdata = 8'h05;
        @(posedge tb_clk); #1;
        penable = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_pslverr", {15'h0, pslverr}, 16'h0);
        check("midrst_prdata", {8'h0, prdata}, 16'h0);
        @(posedge tb_clk); #1;
        psel = 1'b0; penable = 1'b0;
        n_rst = 1'b1;
        bp_m = 14'd10; ds_m = 4'd8;
        check("midrst_data_size", {12'h0, data_size}, 16'd8);
        check("midrst_data_read", {15'h0, data_read}, 16'h0);
        @(posedge tb_clk); #1;
        check("midrst_data_size_after", {12'h0, data_size}, 16'd8);
        apb(mk(0, 3'h4, 8'h00, 8'h00, 0, 0, 0, 8'h08, 0, 0));
        apb(mk(0, 3'h2, 8'h00, 8'h00, 0, 0, 0, 8'h0A, 0, 0));

        check("scoreboard_empty", sb.size(), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
